mux_display_scanner: RTL and testbench

Time-multiplexing controller that shares one combinational binary-to-7-segment decoder among four common-anode digits. Holds a 16-bit display word (four hex nibbles) and scans them in turn. Each scan slot presents the digit's nibble on the decoder input, then enables that digit's anode, with a blanking gap between slots to prevent ghosting. New values are accepted through a load handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/mux_display_scanner.sv | 99 +++++++++
 tb/tb_mux_display_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_display_scanner.sv
// Four-digit time-multiplexed display scanner: blank gap, then drive one anode per slot.
// Loads are buffered and committed only at frame boundaries so a frame never mixes words.
module mux_display_scanner #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_digit_en,
  output logic [3:0]  o_nibble,
  output logic [3:0]  o_anodes,
  output logic [1:0]  o_digit_idx,
  output logic        o_busy,
  output logic        o_load_ack
);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [15:0] BlankLast = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] DriveLast = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_flag_q, pend_flag_d;
  logic        ack_q, ack_d;
  logic        boundary;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    ack_d       = 1'b0;
    boundary    = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == BlankLast) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DriveLast) begin
          state_d  = BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: state_d = BLANK;
    endcase

    // Commit uses the pre-cycle pending word; a same-cycle load re-arms the flag afterwards.
    if (boundary && pend_flag_q) begin
      disp_d      = pend_q;
      pend_flag_d = 1'b0;
      ack_d       = 1'b1;
    end
    if (i_load) begin
      pend_d      = i_value;
      pend_flag_d = 1'b1;
    end
  end

  assign o_nibble    = disp_q[{idx_q, 2'b00} +: 4];
  assign o_digit_idx = idx_q;
  assign o_anodes    = (state_q == DRIVE && i_digit_en[idx_q]) ? ~(4'b0001 << idx_q) : 4'b1111;
  assign o_busy      = pend_flag_q;
  assign o_load_ack  = ack_q;

endmodule

// File: tb/tb_mux_display_scanner.sv
// Directed bench for mux_display_scanner with CLK_DIV=4, BLANK_CYCLES=2 (6-cycle slot, 24-cycle frame).
module tb_mux_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  nibble;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;
  logic        busy;
  logic        load_ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_display_scanner #(
    .CLK_DIV      (4),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_value     (value),
    .i_load      (load),
    .i_digit_en  (digit_en),
    .o_nibble    (nibble),
    .o_anodes    (anodes),
    .o_digit_idx (digit_idx),
    .o_busy      (busy),
    .o_load_ack  (load_ack)
  );

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    return w[k*4 +: 4];
  endfunction

  // Expected anodes for cycle c of a frame (c counted from a BLANK slot start of digit 0).
  function automatic logic [3:0] exp_an(input int c, input logic [3:0] en);
    int slot = (c % 24) / 6;
    int pos  = c % 6;
    logic [3:0] one = 4'b0001;
    if (pos >= 2 && en[slot]) return ~(one << slot);
    return 4'b1111;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; value = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    digit_en = 4'b1111;
    do_reset();
    n_cmp++; if (anodes !== 4'b1111) begin n_err++; $display("FAIL reset_anodes got %b want 1111", anodes); end
    n_cmp++; if (nibble !== 4'h0) begin n_err++; $display("FAIL reset_nibble got %h want 0", nibble); end
    n_cmp++; if (digit_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", digit_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (load_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", load_ack); end
  endtask

  task automatic test_scan();
    logic [3:0] tbl [10] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD};
    digit_en = 4'b1111;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c < 10) begin
        n_cmp++; if (anodes !== tbl[c]) begin n_err++; $display("FAIL scan_tbl c=%0d got %b want %b", c, anodes, tbl[c]); end
      end
      n_cmp++; if (anodes !== exp_an(c, 4'hF)) begin n_err++; $display("FAIL scan_anodes c=%0d got %b want %b", c, anodes, exp_an(c, 4'hF)); end
      n_cmp++; if (digit_idx !== 2'((c % 24) / 6)) begin n_err++; $display("FAIL scan_idx c=%0d got %0d want %0d", c, digit_idx, (c % 24) / 6); end
      n_cmp++; if (nibble !== 4'h0 || load_ack !== 1'b0) begin n_err++; $display("FAIL scan_idle c=%0d nibble %h ack %b want 0 0", c, nibble, load_ack); end
      tick();
    end
  endtask

  task automatic test_load();
    logic [15:0] w = 16'h4321;
    logic [3:0]  en;
    logic [3:0]  exp_n;
    digit_en = 4'b1111;
    en = digit_en;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      load  = (c == 0);
      value = (c == 0) ? w : 16'h0;
      exp_n = (c < 24) ? 4'h0 : nib(w, (c - 24) / 6);
      n_cmp++; if (busy !== (c >= 1 && c <= 23)) begin n_err++; $display("FAIL load_busy c=%0d got %b", c, busy); end
      n_cmp++; if (load_ack !== (c == 24)) begin n_err++; $display("FAIL load_ack c=%0d got %b", c, load_ack); end
      n_cmp++; if (nibble !== exp_n) begin n_err++; $display("FAIL load_nibble c=%0d got %h want %h", c, nibble, exp_n); end
      n_cmp++; if (anodes !== exp_an(c, en)) begin n_err++; $display("FAIL load_anodes c=%0d got %b want %b", c, anodes, exp_an(c, en)); end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_n;
    digit_en = 4'b1111;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      load  = (c == 3) || (c == 10);
      value = (c == 3) ? 16'h1111 : (c == 10) ? 16'hABCD : 16'h0;
      exp_n = (c < 24) ? 4'h0 : nib(16'hABCD, (c - 24) / 6);
      n_cmp++; if (load_ack !== (c == 24)) begin n_err++; $display("FAIL b2b_ack c=%0d got %b", c, load_ack); end
      n_cmp++; if (nibble !== exp_n) begin n_err++; $display("FAIL b2b_nibble c=%0d got %h want %h", c, nibble, exp_n); end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      n_cmp++; if (anodes !== exp_an(c, 4'b0101)) begin n_err++; $display("FAIL en_anodes c=%0d got %b want %b", c, anodes, exp_an(c, 4'b0101)); end
      n_cmp++; if (digit_idx !== 2'((c % 24) / 6)) begin n_err++; $display("FAIL en_idx c=%0d got %0d want %0d", c, digit_idx, (c % 24) / 6); end
      tick();
    end
    digit_en = 4'b1111;
  endtask

  task automatic test_boundary_load();
    logic [3:0] exp_n;
    digit_en = 4'b1111;
    do_reset();
    for (int c = 0; c < 56; c++) begin
      load  = (c == 23);
      value = (c == 23) ? 16'h00F0 : 16'h0;
      exp_n = (c < 48) ? 4'h0 : nib(16'h00F0, (c - 48) / 6);
      n_cmp++; if (load_ack !== (c == 48)) begin n_err++; $display("FAIL bnd_ack c=%0d got %b", c, load_ack); end
      n_cmp++; if (busy !== (c >= 24 && c <= 47)) begin n_err++; $display("FAIL bnd_busy c=%0d got %b", c, busy); end
      n_cmp++; if (nibble !== exp_n) begin n_err++; $display("FAIL bnd_nibble c=%0d got %h want %h", c, nibble, exp_n); end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_midrun();
    digit_en = 4'b1111;
    do_reset();
    for (int c = 0; c < 39; c++) begin
      load  = (c == 0) || (c == 30);
      value = (c == 0) ? 16'h4321 : (c == 30) ? 16'h9999 : 16'h0;
      tick();
    end
    load = 1'b0;
    // cycle 39: digit-2 DRIVE of the second frame, 0x9999 pending
    n_cmp++; if (nibble !== 4'h3 || anodes !== 4'b1011 || busy !== 1'b1) begin
      n_err++; $display("FAIL mid_pre nibble %h anodes %b busy %b want 3 1011 1", nibble, anodes, busy);
    end
    do_reset();
    for (int c = 0; c < 30; c++) begin
      n_cmp++; if (anodes !== exp_an(c, 4'hF)) begin n_err++; $display("FAIL mid_anodes c=%0d got %b want %b", c, anodes, exp_an(c, 4'hF)); end
      n_cmp++; if (nibble !== 4'h0 || busy !== 1'b0 || load_ack !== 1'b0) begin
        n_err++; $display("FAIL mid_state c=%0d nibble %h busy %b ack %b want 0 0 0", c, nibble, busy, load_ack);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; digit_en = 4'b1111;
    #1;
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_digit_en();
    test_boundary_load();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
